// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared widths, control-bit indices and EX register layout
package id_ex_stage_pkg;

    localparam int DW      = 32;
    localparam int AW      = 5;
    localparam int CTRL_W  = 8;
    // Control-bundle bit positions agreed with the control decoder.
    localparam int MEMRD_B = 0;
    localparam int REGWR_B = 1;
    localparam int CNT_W   = 32;

    typedef struct packed {
        logic [DW-1:0]     src_a;
        logic [DW-1:0]     src_b;
        logic [AW-1:0]     rs;
        logic [AW-1:0]     rt;
        logic [AW-1:0]     rd;
        logic [DW-1:0]     imm;
        logic [CTRL_W-1:0] ctrl;
        logic              valid;
    } ex_reg_t;

    function automatic logic ctrl_is_load(input logic [CTRL_W-1:0] ctrl);
        return ctrl[MEMRD_B];
    endfunction

    function automatic logic ctrl_writes_reg(input logic [CTRL_W-1:0] ctrl);
        return ctrl[REGWR_B];
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode, writeback and execute-side signals of the D->E register
interface id_ex_stage_if;
    import id_ex_stage_pkg::*;

    logic [DW-1:0]     RD1D;
    logic [DW-1:0]     RD2D;
    logic [AW-1:0]     RsD;
    logic [AW-1:0]     RtD;
    logic [AW-1:0]     RdD;
    logic [DW-1:0]     ImmD;
    logic [CTRL_W-1:0] CtrlD;
    logic              ValidD;
    logic              RegWriteW;
    logic [AW-1:0]     WriteRegW;
    logic [DW-1:0]     ResultW;
    logic              FlushE;
    logic [DW-1:0]     SrcAE;
    logic [DW-1:0]     SrcBE;
    logic [AW-1:0]     RsE;
    logic [AW-1:0]     RtE;
    logic [AW-1:0]     RdE;
    logic [DW-1:0]     ImmE;
    logic [CTRL_W-1:0] CtrlE;
    logic              ValidE;
    logic              StallD;
    logic [CNT_W-1:0]  BubbleCnt;

    modport slave (
        input  RD1D, RD2D, RsD, RtD, RdD, ImmD, CtrlD, ValidD,
        input  RegWriteW, WriteRegW, ResultW, FlushE,
        output SrcAE, SrcBE, RsE, RtE, RdE, ImmE, CtrlE, ValidE, StallD, BubbleCnt
    );

    modport master (
        output RD1D, RD2D, RsD, RtD, RdD, ImmD, CtrlD, ValidD,
        output RegWriteW, WriteRegW, ResultW, FlushE,
        input  SrcAE, SrcBE, RsE, RtE, RdE, ImmE, CtrlE, ValidE, StallD, BubbleCnt
    );

endinterface

// File: rtl/wb_bypass_mux.sv
// rtl/wb_bypass_mux.sv - selects the same-cycle WB result over stale register-file read data
module wb_bypass_mux #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic [AW-1:0] rf_addr_i,
    input  logic [DW-1:0] rf_data_i,
    input  logic          wb_en_i,
    input  logic [AW-1:0] wb_addr_i,
    input  logic [DW-1:0] wb_data_i,
    output logic [DW-1:0] op_o
);

    // Register 0 is hardwired, so a WB targeting it must never win.
    assign op_o = (wb_en_i && (wb_addr_i != '0) && (wb_addr_i == rf_addr_i)) ? wb_data_i : rf_data_i;

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - D->E pipeline register with WB bypass, load-use bubble and bubble counter
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic          CLK,
    input  logic          reset,
    id_ex_stage_if.slave  bus
);

    logic [DW-1:0]    op_a;
    logic [DW-1:0]    op_b;
    logic             stall;
    logic             bubble;
    ex_reg_t          ex_q;
    ex_reg_t          ex_d;
    logic [CNT_W-1:0] bubble_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_d;

    wb_bypass_mux #(.AW(AW), .DW(DW)) u_bypass_a (
        .rf_addr_i (bus.RsD),
        .rf_data_i (bus.RD1D),
        .wb_en_i   (bus.RegWriteW),
        .wb_addr_i (bus.WriteRegW),
        .wb_data_i (bus.ResultW),
        .op_o      (op_a)
    );

    wb_bypass_mux #(.AW(AW), .DW(DW)) u_bypass_b (
        .rf_addr_i (bus.RtD),
        .rf_data_i (bus.RD2D),
        .wb_en_i   (bus.RegWriteW),
        .wb_addr_i (bus.WriteRegW),
        .wb_data_i (bus.ResultW),
        .op_o      (op_b)
    );

    // Built from registered EX state, so it collapses as soon as reset clears ValidE.
    assign stall  = ex_q.valid && ctrl_is_load(ex_q.ctrl) && (ex_q.rt != '0) && bus.ValidD &&
                    ((ex_q.rt == bus.RsD) || (ex_q.rt == bus.RtD));
    assign bubble = bus.FlushE || stall;

    always_comb begin
        ex_d         = '0;
        bubble_cnt_d = bubble_cnt_q;
        if (!bubble) begin
            ex_d.src_a = op_a;
            ex_d.src_b = op_b;
            ex_d.rs    = bus.RsD;
            ex_d.rt    = bus.RtD;
            ex_d.rd    = bus.RdD;
            ex_d.imm   = bus.ImmD;
            ex_d.ctrl  = bus.CtrlD;
            ex_d.valid = bus.ValidD;
        end else if (bus.ValidD && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            ex_q         <= '0;
            bubble_cnt_q <= '0;
        end else begin
            ex_q         <= ex_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.SrcAE     = ex_q.src_a;
    assign bus.SrcBE     = ex_q.src_b;
    assign bus.RsE       = ex_q.rs;
    assign bus.RtE       = ex_q.rt;
    assign bus.RdE       = ex_q.rd;
    assign bus.ImmE      = ex_q.imm;
    assign bus.CtrlE     = ex_q.ctrl;
    assign bus.ValidE    = ex_q.valid;
    assign bus.StallD    = stall;
    assign bus.BubbleCnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - randomized and directed bench for id_ex_stage against a behavioural model
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic CLK = 1'b0;
    logic reset = 1'b0;
    always #5 CLK = ~CLK;

    id_ex_stage_if bus_if ();

    id_ex_stage dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus_if)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0]     m_a, m_b, m_imm;
    logic [AW-1:0]     m_rs, m_rt, m_rd;
    logic [CTRL_W-1:0] m_ctrl;
    logic              m_valid;
    longint unsigned   m_cnt;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic model_reset();
        m_a = '0; m_b = '0; m_imm = '0;
        m_rs = '0; m_rt = '0; m_rd = '0;
        m_ctrl = '0; m_valid = 1'b0; m_cnt = 0;
    endtask

    function automatic logic model_stall();
        return m_valid && m_ctrl[MEMRD_B] && (m_rt != 0) && bus_if.ValidD &&
               ((m_rt == bus_if.RsD) || (m_rt == bus_if.RtD));
    endfunction

    function automatic logic [DW-1:0] wb_value(input logic [AW-1:0] addr, input logic [DW-1:0] rf);
        if (bus_if.RegWriteW && bus_if.WriteRegW != 0 && bus_if.WriteRegW == addr) return bus_if.ResultW;
        return rf;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".SrcAE"},     bus_if.SrcAE,     m_a);
        check({tag, ".SrcBE"},     bus_if.SrcBE,     m_b);
        check({tag, ".RsE"},       bus_if.RsE,       m_rs);
        check({tag, ".RtE"},       bus_if.RtE,       m_rt);
        check({tag, ".RdE"},       bus_if.RdE,       m_rd);
        check({tag, ".ImmE"},      bus_if.ImmE,      m_imm);
        check({tag, ".CtrlE"},     bus_if.CtrlE,     m_ctrl);
        check({tag, ".ValidE"},    bus_if.ValidE,    m_valid);
        check({tag, ".BubbleCnt"}, bus_if.BubbleCnt, m_cnt);
        check({tag, ".StallD"},    bus_if.StallD,    model_stall());
    endtask

    // Called with inputs settled (after a negedge); returns at the following negedge.
    task automatic step(input string tag);
        logic              bub;
        logic [DW-1:0]     na, nb, nimm;
        logic [AW-1:0]     nrs, nrt, nrd;
        logic [CTRL_W-1:0] nctrl;
        logic              nvalid;
        longint unsigned   ncnt;
        bub = bus_if.FlushE || model_stall();
        ncnt = m_cnt;
        if (bub) begin
            na = '0; nb = '0; nimm = '0; nrs = '0; nrt = '0; nrd = '0; nctrl = '0; nvalid = 1'b0;
            if (bus_if.ValidD && m_cnt < 64'hFFFF_FFFF) ncnt = m_cnt + 1;
        end else begin
            na = wb_value(bus_if.RsD, bus_if.RD1D);
            nb = wb_value(bus_if.RtD, bus_if.RD2D);
            nrs = bus_if.RsD; nrt = bus_if.RtD; nrd = bus_if.RdD;
            nimm = bus_if.ImmD; nctrl = bus_if.CtrlD; nvalid = bus_if.ValidD;
        end
        @(posedge CLK);
        #1;
        m_a = na; m_b = nb; m_imm = nimm; m_rs = nrs; m_rt = nrt; m_rd = nrd;
        m_ctrl = nctrl; m_valid = nvalid; m_cnt = ncnt;
        check_all(tag);
        @(negedge CLK);
    endtask

    task automatic set_d(input logic v, input logic [CTRL_W-1:0] c, input logic [AW-1:0] rs,
                         input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                         input logic [DW-1:0] d1, input logic [DW-1:0] d2, input logic [DW-1:0] imm);
        bus_if.ValidD = v; bus_if.CtrlD = c; bus_if.RsD = rs; bus_if.RtD = rt; bus_if.RdD = rd;
        bus_if.RD1D = d1; bus_if.RD2D = d2; bus_if.ImmD = imm;
    endtask

    task automatic set_wb(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus_if.RegWriteW = en; bus_if.WriteRegW = a; bus_if.ResultW = d;
    endtask

    initial begin
        model_reset();
        set_d(1'b0, '0, '0, '0, '0, '0, '0, '0);
        set_wb(1'b0, '0, '0);
        bus_if.FlushE = 1'b0;

        // Reset held with a live instruction at D must keep EX empty.
        repeat (2) @(posedge CLK);
        set_d(1'b1, 8'h02, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_all("reset");
        reset = 1'b1;
        step("first");
        check("first.valid", bus_if.ValidE, 1'b1);

        set_wb(1'b1, 5'd5, 32'hDEAD_BEEF);
        set_d(1'b1, 8'h02, 5'd5, 5'd3, 5'd7, 32'h0, 32'h123, 32'h4);
        step("byp");
        check("byp.srca", bus_if.SrcAE, 32'hDEAD_BEEF);
        set_wb(1'b1, 5'd0, 32'hDEAD_BEEF);
        set_d(1'b1, 8'h02, 5'd0, 5'd3, 5'd7, 32'h1111, 32'h123, 32'h4);
        step("byp0");
        check("byp0.srca", bus_if.SrcAE, 32'h1111);
        set_wb(1'b0, '0, '0);

        // lw $8 then add using $8: one bubble.
        set_d(1'b1, 8'h03, 5'd1, 5'd8, 5'd0, 32'h100, 32'h0, 32'h10);
        step("lw");
        set_d(1'b1, 8'h02, 5'd8, 5'd9, 5'd10, 32'hA, 32'hB, 32'h0);
        #1 check("lu.stall_on", bus_if.StallD, 1'b1);
        step("lu_bubble");
        check("lu.bubble_valid", bus_if.ValidE, 1'b0);
        check("lu.stall_off", bus_if.StallD, 1'b0);
        step("lu_add");
        check("lu.add_rs", bus_if.RsE, 5'd8);
        check("lu.cnt", bus_if.BubbleCnt, 32'd1);

        set_d(1'b1, 8'h03, 5'd1, 5'd8, 5'd0, 32'h100, 32'h0, 32'h10);
        step("lw2");
        set_d(1'b1, 8'h02, 5'd9, 5'd8, 5'd10, 32'hA, 32'hB, 32'h0);
        bus_if.FlushE = 1'b1;
        step("flush_stall");
        check("fs.cnt", bus_if.BubbleCnt, 32'd2);
        bus_if.FlushE = 1'b0;
        step("fs_after");

        for (int i = 0; i < 400; i++) begin
            set_d($urandom_range(0, 3) != 0, CTRL_W'($urandom), AW'($urandom_range(0, 3)),
                  AW'($urandom_range(0, 3)), AW'($urandom), $urandom, $urandom, $urandom);
            set_wb($urandom_range(0, 1) == 1, AW'($urandom_range(0, 3)), $urandom);
            bus_if.FlushE = ($urandom_range(0, 7) == 0);
            step("rnd");
        end
        bus_if.FlushE = 1'b0;
        set_wb(1'b0, '0, '0);

        force dut.bubble_cnt_q = 32'hFFFF_FFFE;
        #1 release dut.bubble_cnt_q;
        m_cnt = 64'hFFFF_FFFE;
        set_d(1'b1, 8'h02, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3);
        bus_if.FlushE = 1'b1;
        step("sat1");
        check("sat1.cnt", bus_if.BubbleCnt, 32'hFFFF_FFFF);
        step("sat2");
        step("sat3");
        check("sat3.cnt", bus_if.BubbleCnt, 32'hFFFF_FFFF);
        bus_if.FlushE = 1'b0;

        set_d(1'b1, 8'h03, 5'd1, 5'd8, 5'd0, 32'h100, 32'h0, 32'h10);
        step("lw3");
        set_d(1'b1, 8'h02, 5'd8, 5'd9, 5'd10, 32'hA, 32'hB, 32'h0);
        #1 check("ar.stall_on", bus_if.StallD, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("ar.valid", bus_if.ValidE, 1'b0);
        check("ar.stall", bus_if.StallD, 1'b0);
        check("ar.cnt", bus_if.BubbleCnt, 32'd0);
        model_reset();
        @(negedge CLK);
        reset = 1'b1;
        step("ar_release");
        check("ar.add_in", bus_if.ValidE, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
